// File: rtl/key_debounce_reader_pkg.sv
// key_debounce_reader_pkg: shared FSM state encoding and board-level default timing for the key reader
package key_debounce_reader_pkg;
  typedef enum logic [1:0] {
    KST_RELEASED   = 2'd0,
    KST_PRESS_DB   = 2'd1,
    KST_PRESSED    = 2'd2,
    KST_RELEASE_DB = 2'd3
  } key_state_e;
  localparam int DEBOUNCE_50MHZ = 1000000;
endpackage

// File: rtl/key_debounce_reader_if.sv
// key_debounce_reader_if: raw KEY pin in, debounced level/pulse and LEDG press counter out
interface key_debounce_reader_if;
  logic       KEY;
  logic       KEY_LEVEL;
  logic       KEY_PRESS;
  logic [1:0] LEDG;
  modport master (output KEY, input KEY_LEVEL, input KEY_PRESS, input LEDG);
  modport slave  (input KEY, output KEY_LEVEL, output KEY_PRESS, output LEDG);
endinterface

// File: rtl/key_debounce_reader_sync2.sv
// key_sync2: two-flop synchroniser resetting to 1 (idle level of active-low board inputs)
module key_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;
  // shift the asynchronous input through two flops
  always_ff @(posedge clk or posedge rst)
    if (rst) {q, meta} <= 2'b11;
    else     {q, meta} <= {meta, d};
endmodule

// File: rtl/key_debounce_reader.sv
// key_debounce_reader: debounced DE2 KEY reader with press pulse, level and 2-bit press counter; KEY_AUTOREPEAT_EN adds hold auto-repeat
module key_debounce_reader
  import key_debounce_reader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_50MHZ,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input logic                   CLOCK_50,
  input logic                   RESET,
  key_debounce_reader_if.slave  kif
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_db
    $error("DEBOUNCE_CYCLES must be >= 2");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_rep
    $error("REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end
  key_state_e    state;
  logic [CW-1:0] cnt;
  logic          key_s;
  logic          acc;
`ifdef KEY_AUTOREPEAT_EN
  localparam int HW = $clog2((REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD) + 1);
  localparam logic [HW-1:0] DMAX = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] PMAX = HW'(REPEAT_PERIOD - 1);
  logic [HW-1:0] hc;
  logic          rep_armed;
  logic          rep_hit;
  always_comb rep_hit = rep_armed ? hc == PMAX : hc == DMAX;
`endif
  key_sync2 u_sync (.clk(CLOCK_50), .rst(RESET), .d(kif.KEY), .q(key_s));
  // debounce FSM; acceptance is flagged in acc and published one edge later as pulse and count
  always_ff @(posedge CLOCK_50 or posedge RESET)
    if (RESET) begin
      state         <= KST_RELEASED;
      cnt           <= '0;
      acc           <= 1'b0;
      kif.KEY_PRESS <= 1'b0;
      kif.KEY_LEVEL <= 1'b0;
      kif.LEDG      <= 2'b00;
`ifdef KEY_AUTOREPEAT_EN
      hc            <= '0;
      rep_armed     <= 1'b0;
`endif
    end else begin
      acc           <= 1'b0;
      kif.KEY_PRESS <= acc;
      kif.LEDG      <= kif.LEDG + {1'b0, acc};
      kif.KEY_LEVEL <= state == KST_PRESSED || state == KST_RELEASE_DB;
      case (state)
        KST_RELEASED:
          if (!key_s) begin
            state <= KST_PRESS_DB;
            cnt   <= '0;
          end
        KST_PRESS_DB:
          if (key_s) begin
            state <= KST_RELEASED;
            cnt   <= '0;
          end else if (cnt == CMAX) begin
            state     <= KST_PRESSED;
            cnt       <= '0;
            acc       <= 1'b1;
`ifdef KEY_AUTOREPEAT_EN
            hc        <= '0;
            rep_armed <= 1'b0;
`endif
          end else cnt <= cnt + 1'b1;
        KST_PRESSED:
          if (key_s) begin
            state <= KST_RELEASE_DB;
            cnt   <= '0;
          end
`ifdef KEY_AUTOREPEAT_EN
          else if (rep_hit) begin
            acc       <= 1'b1;
            hc        <= '0;
            rep_armed <= 1'b1;
          end else hc <= hc + 1'b1;
`endif
        KST_RELEASE_DB:
          if (!key_s) begin
            state     <= KST_PRESSED;
            cnt       <= '0;
`ifdef KEY_AUTOREPEAT_EN
            hc        <= '0;
            rep_armed <= 1'b0;
`endif
          end else if (cnt == CMAX) begin
            state <= KST_RELEASED;
            cnt   <= '0;
          end else cnt <= cnt + 1'b1;
        default: state <= KST_RELEASED;
      endcase
    end
endmodule

// File: tb/tb_key_debounce_reader.sv
// tb_key_debounce_reader: directed self-checking bench for key_debounce_reader (DEBOUNCE_CYCLES=4)
module tb_key_debounce_reader;
  logic CLOCK_50 = 1'b0;
  logic RESET    = 1'b1;
  int   passed   = 0;
  int   total    = 0;
  int   pulses   = 0;
  int   p0, p1;
  key_debounce_reader_if kif();
  key_debounce_reader #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)) dut (
    .CLOCK_50(CLOCK_50), .RESET(RESET), .kif(kif.slave)
  );
`ifdef KEY_AUTOREPEAT_EN
  localparam int EXP2_PULSES = 3;
  localparam int EXP6_PULSES = 8;
`else
  localparam int EXP2_PULSES = 1;
  localparam int EXP6_PULSES = 1;
`endif
  always #5 CLOCK_50 = ~CLOCK_50;
  // count pulses on the falling edge, away from the active edge
  always @(negedge CLOCK_50) if (kif.KEY_PRESS === 1'b1) pulses <= pulses + 1;
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask
  initial begin
    kif.KEY = 1'b0;
    tick(5);
    chk("rst_level", kif.KEY_LEVEL, 0);
    chk("rst_press", kif.KEY_PRESS, 0);
    chk("rst_ledg", kif.LEDG, 0);
    kif.KEY = 1'b1;
    tick(3);
    RESET = 1'b0;
    tick(4);
    chk("idle_level", kif.KEY_LEVEL, 0);
    p0 = pulses;
    kif.KEY = 1'b0;
    tick(7);
    chk("press_not_early", kif.KEY_PRESS, 0);
    chk("level_not_early", kif.KEY_LEVEL, 0);
    tick(1);
    chk("press_pulse", kif.KEY_PRESS, 1);
    chk("press_level", kif.KEY_LEVEL, 1);
    chk("press_ledg", kif.LEDG, 1);
    tick(1);
    chk("pulse_one_cycle", kif.KEY_PRESS, 0);
    tick(11);
    kif.KEY = 1'b1;
    tick(7);
    chk("release_level_held", kif.KEY_LEVEL, 1);
    tick(1);
    chk("release_level_clear", kif.KEY_LEVEL, 0);
    chk("press_pulse_count", pulses - p0, EXP2_PULSES);
    chk("press_ledg_final", kif.LEDG, EXP2_PULSES % 4);
    tick(3);
    p0 = pulses;
    for (int i = 0; i < 5; i++) begin
      kif.KEY = 1'b0;
      tick(3);
      kif.KEY = 1'b1;
      tick(3);
      chk("bounce_level", kif.KEY_LEVEL, 0);
    end
    tick(10);
    chk("bounce_pulses", pulses - p0, 0);
    chk("bounce_ledg", kif.LEDG, EXP2_PULSES % 4);
    RESET = 1'b1;
    tick(2);
    RESET = 1'b0;
    tick(3);
    p0 = pulses;
    for (int i = 0; i < 5; i++) begin
      kif.KEY = 1'b0;
      tick(10);
      chk("wrap_ledg", kif.LEDG, (i + 1) % 4);
      kif.KEY = 1'b1;
      tick(10);
    end
    chk("wrap_pulses", pulses - p0, 5);
    p0 = pulses;
    kif.KEY = 1'b0;
    tick(4);
    RESET = 1'b1;
    #1;
    chk("midrst_pulses", pulses - p0, 0);
    chk("midrst_press", kif.KEY_PRESS, 0);
    chk("midrst_ledg", kif.LEDG, 0);
    chk("midrst_level", kif.KEY_LEVEL, 0);
    tick(2);
    RESET = 1'b0;
    tick(7);
    chk("midrst_not_early", kif.KEY_PRESS, 0);
    tick(1);
    chk("midrst_pulse", kif.KEY_PRESS, 1);
    chk("midrst_ledg1", kif.LEDG, 1);
    chk("midrst_level1", kif.KEY_LEVEL, 1);
    p1 = pulses;
    tick(30);
    chk("hold_pulses", pulses - p1, EXP6_PULSES);
    chk("hold_ledg", kif.LEDG, EXP6_PULSES % 4);
    kif.KEY = 1'b1;
    tick(10);
    chk("final_level", kif.KEY_LEVEL, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
